asm_dp_datapath: RTL and testbench

Datapath partner of the ASM start/count controller: executes its five register-transfer commands (`clr_AF`, `incr_A`, `set_E`, `clr_E`, `set_F`) on counter A and flags E and F, and returns status bits `A2`/`A3` that the controller samples for its branches. It also tracks the command sequence, flags illegal combinations, and reports run completion. It sits between the controller and the board I/O, in the same clock domain as the controller.

---
 rtl/asm_dp_pkg.sv | 15 +
 rtl/asm_dp_datapath_if.sv | 29 ++
 rtl/asm_dp_checker.sv | 69 ++++++
 rtl/asm_dp_datapath.sv | 85 ++++++++
 tb/tb_asm_dp_datapath.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/asm_dp_pkg.sv
// rtl/asm_dp_pkg.sv - phase encoding and error-code constants for the ASM datapath
package asm_dp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } phase_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_E     = 2'd1;
   localparam logic [1:0] ERR_F     = 2'd2;
   localparam logic [1:0] ERR_PHASE = 2'd3;

endpackage

// File: rtl/asm_dp_datapath_if.sv
// rtl/asm_dp_datapath_if.sv - command and status bundle between ASM controller and datapath
interface asm_dp_datapath_if #(
   parameter int W = 4
);
   logic         clr_AF;
   logic         incr_A;
   logic         set_E;
   logic         clr_E;
   logic         set_F;
   logic [W-1:0] A;
   logic         A2;
   logic         A3;
   logic         E;
   logic         F;
   logic         done;
   logic         err;
   logic [1:0]   err_code;
   logic [W-1:0] run_len;

   modport master (
      output clr_AF, incr_A, set_E, clr_E, set_F,
      input  A, A2, A3, E, F, done, err, err_code, run_len
   );

   modport slave (
      input  clr_AF, incr_A, set_E, clr_E, set_F,
      output A, A2, A3, E, F, done, err, err_code, run_len
   );
endinterface

// File: rtl/asm_dp_checker.sv
// rtl/asm_dp_checker.sv - phase FSM, first-error capture and done pulse; observes commands only
module asm_dp_checker
   import asm_dp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_AF,
   input  logic       incr_A,
   input  logic       set_E,
   input  logic       clr_E,
   input  logic       set_F,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic       in_count,
   output logic       run_end
);

   phase_t     phase;
   phase_t     phase_next;
   logic       phase_err;
   logic [1:0] code_now;

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase    <= IDLE;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         phase <= phase_next;
         if (!err && code_now != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= code_now;
         end
      end
   end

   always_comb begin
      phase_next = phase;
      phase_err  = 1'b0;
      run_end    = 1'b0;
      case (phase)
         IDLE: begin
            if (clr_AF) phase_next = COUNT;
            if (incr_A || set_F) phase_err = 1'b1;
         end
         COUNT: begin
            if (clr_AF) begin
               phase_err = 1'b1;
            end else if (set_F) begin
               phase_next = DONE;
               run_end    = 1'b1;
            end
         end
         DONE:    phase_next = clr_AF ? COUNT : IDLE;
         default: phase_next = IDLE;
      endcase

      // Lowest code wins when several errors coincide.
      if (set_E && clr_E)       code_now = ERR_E;
      else if (clr_AF && set_F) code_now = ERR_F;
      else if (phase_err)       code_now = ERR_PHASE;
      else                      code_now = ERR_NONE;
   end

   assign done     = (phase == DONE);
   assign in_count = (phase == COUNT);

endmodule

// File: rtl/asm_dp_datapath.sv
// rtl/asm_dp_datapath.sv - counter A, flags E/F and run length; ASM_DP_RUNLEN_EN builds run_len
module asm_dp_datapath
   import asm_dp_pkg::*;
#(
   parameter int W = 4
) (
   input logic              clk,
   input logic              rst,
   asm_dp_datapath_if.slave bus
);

   logic [W-1:0] a_q;
   logic         e_q;
   logic         f_q;
   logic         in_count;
   logic         run_end;

   asm_dp_checker u_checker (
      .clk      (clk),
      .rst      (rst),
      .clr_AF   (bus.clr_AF),
      .incr_A   (bus.incr_A),
      .set_E    (bus.set_E),
      .clr_E    (bus.clr_E),
      .set_F    (bus.set_F),
      .done     (bus.done),
      .err      (bus.err),
      .err_code (bus.err_code),
      .in_count (in_count),
      .run_end  (run_end)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q <= '0;
         e_q <= 1'b0;
         f_q <= 1'b0;
      end else begin
         if (bus.clr_AF)      a_q <= '0;
         else if (bus.incr_A) a_q <= a_q + 1'b1;

         // A conflicting set/clear pair holds E.
         if (bus.set_E && !bus.clr_E)      e_q <= 1'b1;
         else if (bus.clr_E && !bus.set_E) e_q <= 1'b0;

         if (bus.clr_AF)     f_q <= 1'b0;
         else if (bus.set_F) f_q <= 1'b1;
      end
   end

   assign bus.A  = a_q;
   assign bus.A2 = a_q[2];
   assign bus.A3 = a_q[3];
   assign bus.E  = e_q;
   assign bus.F  = f_q;

`ifdef ASM_DP_RUNLEN_EN
   logic [W-1:0] cnt;
   logic [W-1:0] cnt_next;
   logic [W-1:0] run_len_q;

   always_comb begin
      cnt_next = cnt;
      if (bus.clr_AF)                             cnt_next = '0;
      else if (in_count && bus.incr_A && cnt != '1) cnt_next = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         run_len_q <= '0;
      end else begin
         cnt <= cnt_next;
         if (run_end) run_len_q <= cnt_next;
      end
   end

   assign bus.run_len = run_len_q;
`else
   logic unused_runlen;
   assign unused_runlen = in_count | run_end;
   assign bus.run_len   = '0;
`endif

endmodule

// File: tb/tb_asm_dp_datapath.sv
// tb/tb_asm_dp_datapath.sv - directed self-checking bench for asm_dp_datapath
module tb_asm_dp_datapath;

   localparam int W = 4;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   asm_dp_datapath_if #(.W(W)) bus ();

   asm_dp_datapath #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic c_clr_AF, input logic c_incr_A, input logic c_set_E,
                      input logic c_clr_E, input logic c_set_F, input int cycles);
      bus.clr_AF = c_clr_AF;
      bus.incr_A = c_incr_A;
      bus.set_E  = c_set_E;
      bus.clr_E  = c_clr_E;
      bus.set_F  = c_set_F;
      repeat (cycles) @(posedge clk);
      #1;
      bus.clr_AF = 1'b0;
      bus.incr_A = 1'b0;
      bus.set_E  = 1'b0;
      bus.clr_E  = 1'b0;
      bus.set_F  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cmd(1, 1, 1, 1, 1, 2);
      rst = 1'b1;
   endtask

   logic [7:0] exp_rl12;
   logic [7:0] exp_rl_sat;

   initial begin
      tests = 0;
      fails = 0;
`ifdef ASM_DP_RUNLEN_EN
      exp_rl12   = 8'd12;
      exp_rl_sat = 8'd15;
`else
      exp_rl12   = 8'd0;
      exp_rl_sat = 8'd0;
`endif
      rst = 1'b0;
      bus.clr_AF = 1'b0;
      bus.incr_A = 1'b0;
      bus.set_E  = 1'b0;
      bus.clr_E  = 1'b0;
      bus.set_F  = 1'b0;
      @(negedge clk);

      // Reset with every command high
      do_reset();
      chk("rst_A", bus.A, 0);
      chk("rst_E", bus.E, 0);
      chk("rst_F", bus.F, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_code", bus.err_code, 0);
      chk("rst_runlen", bus.run_len, 0);

      // Run of 12 increments
      cmd(1, 0, 0, 0, 0, 1);
      cmd(0, 1, 0, 0, 0, 12);
      chk("run_A12", bus.A, 12);
      chk("run_A3", bus.A3, 1);
      chk("run_A2", bus.A2, 1);
      chk("run_noerr", bus.err, 0);
      cmd(0, 0, 0, 0, 1, 1);
      chk("end_F", bus.F, 1);
      chk("end_done", bus.done, 1);
      chk("end_runlen", bus.run_len, exp_rl12);
      cmd(0, 0, 0, 0, 0, 1);
      chk("end_done_drop", bus.done, 0);
      chk("end_F_hold", bus.F, 1);

      // Wrap 15 -> 0 and run-length saturation
      cmd(1, 0, 0, 0, 0, 1);
      chk("clr_F", bus.F, 0);
      cmd(0, 1, 0, 0, 0, 15);
      chk("wrap_A15", bus.A, 15);
      cmd(0, 1, 0, 0, 0, 1);
      chk("wrap_A0", bus.A, 0);
      chk("wrap_A2", bus.A2, 0);
      chk("wrap_A3", bus.A3, 0);
      chk("wrap_noerr", bus.err, 0);
      cmd(0, 0, 0, 0, 1, 1);
      chk("sat_done", bus.done, 1);
      chk("sat_runlen", bus.run_len, exp_rl_sat);
      cmd(0, 0, 0, 0, 0, 1);

      // E conflict, then a later out-of-phase command
      cmd(0, 0, 1, 0, 0, 1);
      chk("setE", bus.E, 1);
      cmd(0, 0, 1, 1, 0, 1);
      chk("econf_E", bus.E, 1);
      chk("econf_err", bus.err, 1);
      chk("econf_code", bus.err_code, 1);
      cmd(0, 1, 0, 0, 0, 1);
      chk("econf_A", bus.A, 1);
      chk("econf_code_kept", bus.err_code, 1);
      cmd(0, 0, 0, 1, 0, 1);
      chk("clrE", bus.E, 0);

      // Out-of-phase increment, then F conflict in COUNT
      do_reset();
      cmd(0, 1, 0, 0, 0, 1);
      chk("oop_A", bus.A, 1);
      chk("oop_err", bus.err, 1);
      chk("oop_code", bus.err_code, 3);
      cmd(1, 0, 0, 0, 0, 1);
      cmd(0, 0, 0, 0, 1, 1);
      chk("pre_fconf_F", bus.F, 1);
      cmd(0, 0, 0, 0, 0, 1);
      cmd(1, 0, 0, 0, 0, 1);
      cmd(0, 0, 0, 0, 1, 1);
      cmd(0, 0, 0, 0, 0, 1);
      cmd(1, 0, 0, 0, 1, 1);
      chk("fconf_F", bus.F, 0);
      chk("fconf_done", bus.done, 0);
      chk("fconf_code", bus.err_code, 3);

      // First error in a cycle with F and phase conflicts together
      do_reset();
      cmd(1, 0, 0, 0, 0, 1);
      cmd(1, 0, 0, 0, 1, 1);
      chk("fconf2_code", bus.err_code, 2);
      chk("fconf2_done", bus.done, 0);

      // Back-to-back run and reset mid-run
      do_reset();
      cmd(1, 0, 0, 0, 0, 1);
      cmd(0, 1, 0, 0, 0, 2);
      cmd(0, 0, 0, 0, 1, 1);
      chk("b2b_done", bus.done, 1);
      cmd(1, 0, 0, 0, 0, 1);
      chk("b2b_err", bus.err, 0);
      chk("b2b_done_drop", bus.done, 0);
      chk("b2b_F", bus.F, 0);
      cmd(0, 1, 0, 0, 0, 5);
      chk("b2b_A5", bus.A, 5);
      chk("b2b_count_noerr", bus.err, 0);
      rst = 1'b0;
      cmd(0, 1, 0, 0, 0, 1);
      rst = 1'b1;
      chk("mid_rst_A", bus.A, 0);
      chk("mid_rst_err", bus.err, 0);
      cmd(0, 0, 0, 0, 1, 1);
      chk("mid_rst_idle_code", bus.err_code, 3);
      chk("mid_rst_idle_done", bus.done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
